// File: rtl/freq_meter.sv
// Gated-window frequency meter.
// Counts rising edges of an asynchronous input over GATE_CYCLES clk_50m cycles,
// then publishes the count (Hz for a 1 s gate) with a one-cycle valid pulse.
// A window is GATE_CYCLES counting cycles plus one latch cycle in which edges
// are ignored, so back-to-back windows repeat every GATE_CYCLES+1 clocks.
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int GATE_W      = 28,
    parameter int FREQ_W      = 26
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              en,
    input  logic              sig_in,
    output logic [FREQ_W-1:0] freq_out,
    output logic              freq_valid,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [FREQ_W-1:0] EDGE_MAX  = '1;

    state_t              state;
    state_t              state_nxt;
    logic                s1;
    logic                s2;
    logic                s3;
    logic                rise;
    logic                gate_last;
    logic [GATE_W-1:0]   gate_cnt;
    logic [FREQ_W-1:0]   edge_cnt;
    logic [FREQ_W-1:0]   edge_nxt;
    logic                sat;
    logic                sat_nxt;
    logic                counting;
    logic                closing;

    assign rise      = s2 & ~s3;
    assign gate_last = (gate_cnt == GATE_LAST);
    // Counters advance only while staying in GATE; every other path clears them.
    assign counting  = (state == GATE) && (state_nxt == GATE);
    // The result is captured on the edge that leaves GATE for LATCH.
    assign closing   = (state == GATE) && (state_nxt == LATCH);

    // Two-flop synchronizer for sig_in plus one delay flop for edge detection.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Saturating edge count: hold at all-ones and flag any edge beyond it.
    always_comb begin
        edge_nxt = edge_cnt;
        sat_nxt  = sat;
        if (rise) begin
            if (edge_cnt == EDGE_MAX) begin
                sat_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; dropping en aborts an open window before it can latch.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = en ? GATE : IDLE;
            GATE: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (gate_last) begin
                    state_nxt = LATCH;
                end else begin
                    state_nxt = GATE;
                end
            end
            LATCH:   state_nxt = en ? GATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gate and edge counters; cleared whenever the window is not continuing.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (counting) begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_nxt;
            sat      <= sat_nxt;
        end else begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end
    end

    // Published result, including an edge seen on the final gate cycle.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            freq_out <= '0;
            overflow <= 1'b0;
        end else if (closing) begin
            freq_out <= edge_nxt;
            overflow <= sat_nxt;
        end
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        busy       = (state == GATE);
        freq_valid = (state == LATCH);
    end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter with a 100-cycle gate.
// Two instances share the stimulus: a 26-bit counter and a 4-bit counter that
// saturates. Expected results come from the recorded sample history of sig_in:
// a window's count is the number of 0->1 steps in the synchronized sample
// stream over the 100 gate cycles preceding the valid pulse.
module tb_freq_meter;

    localparam int GATE = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sig_in;
    logic [25:0] freq_a;
    logic        valid_a;
    logic        ovf_a;
    logic        busy_a;
    logic [3:0]  freq_b;
    logic        valid_b;
    logic        ovf_b;
    logic        busy_b;

    int   cyc = 0;
    logic hist [0:16383];
    int   n_chk = 0;
    int   n_pass = 0;
    int   mode = 0;
    int   per = 10;
    int   phase = 0;
    int   lvl = 0;
    int   sched_cyc = -1;
    int   sched_lvl = 0;

    freq_meter #(.GATE_CYCLES(GATE), .GATE_W(8), .FREQ_W(26)) dut_a (
        .clk_50m(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq_out(freq_a), .freq_valid(valid_a), .overflow(ovf_a), .busy(busy_a)
    );

    freq_meter #(.GATE_CYCLES(GATE), .GATE_W(8), .FREQ_W(4)) dut_b (
        .clk_50m(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq_out(freq_b), .freq_valid(valid_b), .overflow(ovf_b), .busy(busy_b)
    );

    always #10 clk = ~clk;

    // Record what the first synchronizer flop sees at each edge (0 while in reset).
    always @(posedge clk) begin
        hist[cyc] <= rst ? 1'b0 : sig_in;
        cyc       <= cyc + 1;
    end

    // Rising steps that land in the 100 gate cycles closed by the valid at edge v.
    function automatic int model_cnt(input int v);
        int c = 0;
        for (int m = v - GATE; m <= v - 1; m++) begin
            if (hist[m-1] === 1'b1 && hist[m-2] === 1'b0) c++;
        end
        return c;
    endfunction

    // Advance one clock, then drive sig_in for the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cyc == sched_cyc) lvl = sched_lvl;
        case (mode)
            0:       sig_in = lvl[0];
            1:       sig_in = ((cyc + phase) % per) < (per / 2);
            default: sig_in = $urandom_range(0, 1) == 1;
        endcase
    endtask

    // Park in IDLE, select a stimulus, then raise en; e is the edge that opens the gate.
    task automatic start_run(input int m, input int p, output int e);
        en = 1'b0;
        repeat (3) tick();
        mode  = m;
        per   = p;
        phase = $urandom_range(0, p - 1);
        repeat (4) tick();
        en = 1'b1;
        e  = cyc;
    endtask

    // Follow nwin windows opened at edge e; explicit values of -1 are skipped.
    task automatic run_windows(input int e, input int nwin, input int want_a,
                               input int want_b, input int want_ovf_b);
        int v;
        int c;
        int exp_b;
        bit early;
        for (int k = 0; k < nwin; k++) begin
            v     = e + GATE + k * (GATE + 1);
            early = 1'b0;
            while (cyc - 1 < v) begin
                tick();
                if (cyc - 1 < v && (valid_a || valid_b)) early = 1'b1;
            end
            c     = model_cnt(v);
            exp_b = (c > 15) ? 15 : c;
            n_chk++;
            if (early) $display("FAIL early_valid edge=%0d got pulse before window end want none", v);
            else n_pass++;
            n_chk++;
            if (valid_a !== 1'b1 || valid_b !== 1'b1)
                $display("FAIL valid edge=%0d got a=%b b=%b want 1", v, valid_a, valid_b);
            else n_pass++;
            n_chk++;
            if (busy_a !== 1'b0) $display("FAIL latch_busy edge=%0d got %b want 0", v, busy_a);
            else n_pass++;
            n_chk++;
            if (freq_a !== 26'(c) || ovf_a !== 1'b0)
                $display("FAIL freq_a edge=%0d got %0d/%b want %0d/0", v, freq_a, ovf_a, c);
            else n_pass++;
            n_chk++;
            if (freq_b !== 4'(exp_b) || ovf_b !== (c > 15))
                $display("FAIL freq_b edge=%0d got %0d/%b want %0d/%b", v, freq_b, ovf_b, exp_b, c > 15);
            else n_pass++;
            if (want_a >= 0) begin
                n_chk++;
                if (freq_a !== 26'(want_a))
                    $display("FAIL expect_a edge=%0d got %0d want %0d", v, freq_a, want_a);
                else n_pass++;
            end
            if (want_b >= 0) begin
                n_chk++;
                if (freq_b !== 4'(want_b) || ovf_b !== want_ovf_b[0])
                    $display("FAIL expect_b edge=%0d got %0d/%b want %0d/%0d", v, freq_b, ovf_b, want_b, want_ovf_b);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        en     = 1'b0;
        sig_in = 1'b0;
        mode   = 0;
        lvl    = 0;
        repeat (3) tick();
        n_chk++;
        if (freq_a !== 26'd0 || valid_a !== 1'b0 || ovf_a !== 1'b0 || busy_a !== 1'b0)
            $display("FAIL reset_a got %0d/%b/%b/%b want 0/0/0/0", freq_a, valid_a, ovf_a, busy_a);
        else n_pass++;
        n_chk++;
        if (freq_b !== 4'd0 || valid_b !== 1'b0 || ovf_b !== 1'b0 || busy_b !== 1'b0)
            $display("FAIL reset_b got %0d/%b/%b/%b want 0/0/0/0", freq_b, valid_b, ovf_b, busy_b);
        else n_pass++;
        #3 rst = 1'b0;
        repeat (5) tick();
        n_chk++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0)
            $display("FAIL idle_hold got busy=%b valid=%b want 0/0", busy_a, valid_a);
        else n_pass++;
    endtask

    task automatic test_period10();
        int e;
        start_run(1, 10, e);
        tick();
        n_chk++;
        if (busy_a !== 1'b1) $display("FAIL gate_busy got %b want 1", busy_a);
        else n_pass++;
        run_windows(e, 3, 10, 10, 0);
    endtask

    task automatic test_constant();
        int e;
        lvl = 0;
        start_run(0, 2, e);
        sched_cyc = e + GATE + 1 + 40;
        sched_lvl = 1;
        run_windows(e, 1, 0, 0, 0);
        run_windows(e + GATE + 1, 1, 1, 1, 0);
        run_windows(e + 2 * (GATE + 1), 1, 0, 0, 0);
        sched_cyc = -1;
    endtask

    task automatic test_toggle();
        int e;
        start_run(1, 2, e);
        run_windows(e, 3, 50, 15, 1);
    endtask

    task automatic test_saturation();
        int e;
        start_run(1, 4, e);
        run_windows(e, 2, 25, 15, 1);
        per = 20;
        run_windows(e + 2 * (GATE + 1), 1, -1, -1, -1);
        run_windows(e + 3 * (GATE + 1), 2, 5, 5, 0);
    endtask

    task automatic test_abort();
        int  e;
        int  v0;
        bit  stray;
        start_run(1, 10, e);
        run_windows(e, 1, 10, 10, 0);
        v0 = e + GATE;
        while (cyc - 1 < v0 + 51) tick();
        n_chk++;
        if (busy_a !== 1'b1) $display("FAIL abort_pre_busy got %b want 1", busy_a);
        else n_pass++;
        en = 1'b0;
        tick();
        n_chk++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0)
            $display("FAIL abort_busy got a=%b b=%b want 0", busy_a, busy_b);
        else n_pass++;
        stray = valid_a | valid_b;
        repeat (10) begin
            tick();
            stray |= valid_a | valid_b;
        end
        n_chk++;
        if (stray) $display("FAIL abort_valid got pulse want none");
        else n_pass++;
        n_chk++;
        if (freq_a !== 26'd10 || ovf_a !== 1'b0)
            $display("FAIL abort_hold got %0d/%b want 10/0", freq_a, ovf_a);
        else n_pass++;
        en = 1'b1;
        e  = cyc;
        run_windows(e, 1, 10, 10, 0);
    endtask

    task automatic test_reset_mid();
        int e;
        int v;
        start_run(1, 10, e);
        run_windows(e, 1, 10, 10, 0);
        v = e + GATE;
        while (cyc - 1 < v + 61) tick();
        #3 rst = 1'b1;
        #1;
        n_chk++;
        if (freq_a !== 26'd0 || valid_a !== 1'b0 || ovf_a !== 1'b0 || busy_a !== 1'b0)
            $display("FAIL async_rst got %0d/%b/%b/%b want 0/0/0/0", freq_a, valid_a, ovf_a, busy_a);
        else n_pass++;
        repeat (2) tick();
        n_chk++;
        if (busy_b !== 1'b0 || freq_b !== 4'd0)
            $display("FAIL rst_hold got busy=%b freq=%0d want 0/0", busy_b, freq_b);
        else n_pass++;
        #3 rst = 1'b0;
        e = cyc;
        run_windows(e, 1, -1, -1, -1);
        run_windows(e + GATE + 1, 1, 10, 10, 0);
    endtask

    task automatic test_random();
        int e;
        start_run(2, 2, e);
        run_windows(e, 3, -1, -1, -1);
    endtask

    initial begin
        test_reset();
        test_period10();
        test_constant();
        test_toggle();
        test_saturation();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
